fifo_wr_arb: RTL

Round-robin write-port arbiter that shares the write side of the async FIFO among NREQ requesters. It runs entirely in the FIFO write clock domain and sits directly in front of the FIFO's wdata/winc/wfull port. Each requester transfers whole packets over a valid/ready/last handshake. A grant is locked to one requester until that requester's last beat is accepted.

---
 rtl/fifo_arb_pkg.sv | 26 ++
 rtl/fifo_wr_arb_if.sv | 42 ++++
 rtl/fifo_wr_arb_chk.sv | 27 ++
 rtl/fifo_wr_arb_rr_pick.sv | 28 ++
 rtl/fifo_wr_arb.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding and
// the one-hot to index helper used to locate the current owner.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_t;

   localparam int unsigned MAX_REQ = 16;
   localparam int unsigned MAX_IW  = 4;

   function automatic logic [MAX_IW-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [MAX_IW-1:0] idx;
      idx = 4'd0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) begin
            idx = idx | MAX_IW'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Requester and FIFO-write bundle of the write-port arbiter. The slave modport
// is the arbiter; the master modport is the requesters plus the FIFO full flag.
interface fifo_wr_arb_if #(
   parameter int NREQ  = 4,
   parameter int DSIZE = 8
);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*DSIZE-1:0] req_data;
   logic [NREQ-1:0]       req_last;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       grant;
   logic                  busy;
   logic [DSIZE-1:0]      wdata;
   logic                  winc;
   logic                  wfull;

   modport master (
      output req_valid,
      output req_data,
      output req_last,
      output wfull,
      input  req_ready,
      input  grant,
      input  busy,
      input  wdata,
      input  winc
   );

   modport slave (
      input  req_valid,
      input  req_data,
      input  req_last,
      input  wfull,
      output req_ready,
      output grant,
      output busy,
      output wdata,
      output winc
   );

endinterface

// File: rtl/fifo_wr_arb_chk.sv
// Output invariants of the write-port arbiter, kept apart from the datapath
// and evaluated on every rising edge outside reset.
module fifo_wr_arb_chk #(
   parameter int NREQ = 4
) (
   input logic            clk,
   input logic            rst,
   input logic [NREQ-1:0] grant,
   input logic            busy,
   input logic            winc,
   input logic            wfull,
   input logic [NREQ-1:0] req_ready
);

   // The FIFO must never see a write while full or without an owner.
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_no_winc_full:   assert (!(winc && wfull));
         a_no_winc_idle:   assert (!(winc && (grant == {NREQ{1'b0}})));
         a_grant_onehot:   assert ($onehot0(grant));
         a_busy_tracks:    assert (busy == (grant != {NREQ{1'b0}}));
         a_ready_is_owner: assert ((req_ready & ~grant) == {NREQ{1'b0}});
      end else begin
      end
   end

endmodule

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: one-hot grant for the first request at or
// after ptr, wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic            valid
);

   logic [2*NREQ-1:0] dbl_s;
   logic [NREQ-1:0]   rot_s;
   logic [NREQ-1:0]   rot_oh_s;
   logic [2*NREQ-1:0] gnt_dbl_s;

   // Rotate ptr down to bit 0, isolate the lowest set bit, then fold it back.
   always_comb begin
      dbl_s     = {req, req};
      rot_s     = NREQ'(dbl_s >> ptr);
      rot_oh_s  = rot_s & (~rot_s + NREQ'(1));
      gnt_dbl_s = {{NREQ{1'b0}}, rot_oh_s} << ptr;
      gnt       = gnt_dbl_s[NREQ-1:0] | gnt_dbl_s[2*NREQ-1:NREQ];
      valid     = |req;
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin, packet-locked arbiter sharing the async FIFO write port among
// NREQ requesters; runs entirely in the write clock domain.
module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DSIZE = 8
) (
   input logic            wclk,
   input logic            wrst,
   fifo_wr_arb_if.slave   bus
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_t         state_r;
   arb_state_t         state_nxt_s;
   logic [NREQ-1:0]    grant_r;
   logic [NREQ-1:0]    grant_nxt_s;
   logic               busy_r;
   logic               busy_nxt_s;
   logic [IW-1:0]      rr_ptr_r;
   logic [IW-1:0]      rr_ptr_nxt_s;

   logic [NREQ-1:0]    pick_gnt_s;
   logic               pick_valid_s;
   logic [MAX_REQ-1:0] grant_ext_s;
   logic [IW-1:0]      grant_idx_s;
   logic               owner_valid_s;
   logic               owner_last_s;
   logic               xfer_s;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req   (bus.req_valid),
      .ptr   (rr_ptr_r),
      .gnt   (pick_gnt_s),
      .valid (pick_valid_s)
   );

   // Owner index and the owner's handshake qualifiers.
   always_comb begin
      grant_ext_s             = {MAX_REQ{1'b0}};
      grant_ext_s[NREQ-1:0]   = grant_r;
      grant_idx_s             = IW'(onehot_to_idx(grant_ext_s));
      owner_valid_s           = |(bus.req_valid & grant_r);
      owner_last_s            = |(bus.req_last & grant_r);
      xfer_s                  = (state_r == ST_LOCK) && owner_valid_s && !bus.wfull;
   end

   // State, grant, busy and round-robin pointer registers.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_r  <= ST_IDLE;
         grant_r  <= {NREQ{1'b0}};
         busy_r   <= 1'b0;
         rr_ptr_r <= {IW{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         grant_r  <= grant_nxt_s;
         busy_r   <= busy_nxt_s;
         rr_ptr_r <= rr_ptr_nxt_s;
      end
   end

   // Next-state logic: lock on a pick, release on the owner's accepted last beat.
   always_comb begin
      state_nxt_s  = state_r;
      grant_nxt_s  = grant_r;
      busy_nxt_s   = busy_r;
      rr_ptr_nxt_s = rr_ptr_r;
      case (state_r)
         ST_IDLE: begin
            if (pick_valid_s) begin
               state_nxt_s = ST_LOCK;
               grant_nxt_s = pick_gnt_s;
               busy_nxt_s  = 1'b1;
            end else begin
               grant_nxt_s = {NREQ{1'b0}};
               busy_nxt_s  = 1'b0;
            end
         end
         ST_LOCK: begin
            // A lock without an owner can only come from an upset; drop back to idle.
            if (grant_r == {NREQ{1'b0}}) begin
               state_nxt_s = ST_IDLE;
               busy_nxt_s  = 1'b0;
            end else if (xfer_s && owner_last_s) begin
               state_nxt_s  = ST_IDLE;
               grant_nxt_s  = {NREQ{1'b0}};
               busy_nxt_s   = 1'b0;
               rr_ptr_nxt_s = (grant_idx_s == IW'(NREQ - 1)) ? {IW{1'b0}}
                                                             : grant_idx_s + IW'(1);
            end else begin
               state_nxt_s = ST_LOCK;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            grant_nxt_s = {NREQ{1'b0}};
            busy_nxt_s  = 1'b0;
         end
      endcase
   end

   // Output logic: owner's ready/data steered to the FIFO, gated by wfull.
   always_comb begin
      bus.req_ready = {NREQ{1'b0}};
      bus.winc      = 1'b0;
      bus.wdata     = {DSIZE{1'b0}};
      bus.grant     = grant_r;
      bus.busy      = busy_r;
      if (state_r == ST_LOCK) begin
         bus.req_ready = grant_r & {NREQ{!bus.wfull}};
         bus.winc      = xfer_s;
         for (int i = 0; i < NREQ; i++) begin
            if (grant_r[i]) begin
               bus.wdata = bus.wdata | bus.req_data[i*DSIZE +: DSIZE];
            end else begin
               bus.wdata = bus.wdata;
            end
         end
      end else begin
         bus.req_ready = {NREQ{1'b0}};
      end
   end

   fifo_wr_arb_chk #(
      .NREQ (NREQ)
   ) u_chk (
      .clk       (wclk),
      .rst       (wrst),
      .grant     (grant_r),
      .busy      (busy_r),
      .winc      (bus.winc),
      .wfull     (bus.wfull),
      .req_ready (bus.req_ready)
   );

endmodule
